mux_pipe: RTL

//   Parametrised N-way, WIDTH-bit registered multiplexer with valid/ready handshakes on every input

---
 rtl/mux_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/mux_pipe.sv
module mux_pipe #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   head_data_q, head_data_d;
  logic [SEL_W-1:0]   head_sel_q, head_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;

  logic [WIDTH-1:0]   sel_data;
  logic               accept;
  logic               drain;

  // An out-of-range sel matches no channel, so nothing is muxed and no ready is raised.
  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data    = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = rst_n && (state_q != FULL);
      end
    end
  end

  assign accept    = |(in_valid & in_ready);
  assign out_valid = (state_q != EMPTY);
  assign drain     = out_valid && out_ready;
  assign out_data  = head_data_q;
  assign out_sel   = head_sel_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_d = sel_data;
          head_sel_d  = sel;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_data_d = sel_data;
          head_sel_d  = sel;
        end else if (accept) begin
          skid_data_d = sel_data;
          skid_sel_d  = sel;
          state_d     = FULL;
        end else if (drain) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

endmodule
